// File: rtl/interrupt_request_ctrl_if.sv
// Request/handshake bus between the interrupt request controller and the
// interrupt handler.
//   hdl_busy   : handler -> controller, handler is still running
//   req_ack    : handler -> controller, handler accepts the presented request
//   req_valid  : controller -> handler, a request is being presented
//   req_vector : controller -> handler, vector low-byte address
//   req_kind   : controller -> handler, 00 reset, 01 NMI, 10 BRK, 11 IRQ
// modport master: controller side.
// modport slave:  handler side.
interface interrupt_request_ctrl_if;
  logic        hdl_busy;
  logic        req_ack;
  logic        req_valid;
  logic [15:0] req_vector;
  logic [1:0]  req_kind;

  modport master (
    input  hdl_busy,
    input  req_ack,
    output req_valid,
    output req_vector,
    output req_kind
  );

  modport slave (
    output hdl_busy,
    output req_ack,
    input  req_valid,
    input  req_vector,
    input  req_kind
  );
endinterface

// File: rtl/interrupt_request_ctrl.sv
// Interrupt request controller.
// Latches soft reset, NMI (rising edge of nmi_src) and BRK events, and at an
// instruction boundary presents the highest-priority pending source
// (reset > NMI > BRK > IRQ) to the interrupt handler through the bus
// interface. The request is held stable until the handler acknowledges it,
// then the controller waits for the handler to go idle before it may present
// another request.
//
// Configuration macro: IRQ_EN. When defined, the level-sensitive maskable IRQ
// (irq_n low and i_flag clear) is an eligible source. When undefined, irq_n
// and i_flag are ignored and kind 2'b11 is never produced.
//
// Ports:
//   clk            : clock
//   rst            : asynchronous active-low reset
//   nmi_src        : PPU vblank/NMI level
//   irq_n          : active-low maskable IRQ level
//   soft_reset     : one-cycle soft reset pulse
//   brk            : one-cycle pulse when BRK is decoded
//   i_flag         : interrupt-disable status bit
//   instr_boundary : one-cycle pulse at an instruction boundary
//   bus            : master side of interrupt_request_ctrl_if
//                    (hdl_busy, req_ack in; req_valid, req_vector, req_kind out)
//   nmi_count      : number of acknowledged NMIs, wraps at 256
module interrupt_request_ctrl (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            nmi_src,
  input  logic                            irq_n,
  input  logic                            soft_reset,
  input  logic                            brk,
  input  logic                            i_flag,
  input  logic                            instr_boundary,
  interrupt_request_ctrl_if.master        bus,
  output logic [7:0]                      nmi_count
);

  localparam logic [1:0]  KIND_RST = 2'b00;
  localparam logic [1:0]  KIND_NMI = 2'b01;
  localparam logic [1:0]  KIND_BRK = 2'b10;
  localparam logic [1:0]  KIND_IRQ = 2'b11;

  localparam logic [15:0] VEC_RST     = 16'hFFFC;
  localparam logic [15:0] VEC_NMI     = 16'hFFFA;
  localparam logic [15:0] VEC_IRQ_BRK = 16'hFFFE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t      state;
  logic        nmi_q;
  logic        rst_pend;
  logic        nmi_pend;
  logic        brk_pend;

  logic        nmi_rise;
  logic        irq_eligible;
  logic        any_eligible;
  logic        take;
  logic        ack_fire;
  logic        clr_rst;
  logic        clr_nmi;
  logic        clr_brk;
  logic [1:0]  sel_kind;
  logic [15:0] sel_vector;

  assign nmi_rise = nmi_src & ~nmi_q;

`ifdef IRQ_EN
  // IRQ is a live level, never latched: it only counts while it is asserted
  // and unmasked at the boundary itself.
  assign irq_eligible = ~irq_n & ~i_flag;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = irq_n ^ i_flag;
  assign irq_eligible      = 1'b0;
`endif

  assign any_eligible = rst_pend | nmi_pend | brk_pend | irq_eligible;

  // Priority selection; the IRQ fallthrough is only taken when irq_eligible
  // is what made any_eligible true.
  always_comb begin
    sel_kind   = KIND_IRQ;
    sel_vector = VEC_IRQ_BRK;
    if (rst_pend) begin
      sel_kind   = KIND_RST;
      sel_vector = VEC_RST;
    end else if (nmi_pend) begin
      sel_kind   = KIND_NMI;
      sel_vector = VEC_NMI;
    end else if (brk_pend) begin
      sel_kind   = KIND_BRK;
      sel_vector = VEC_IRQ_BRK;
    end
  end

  assign take     = (state == IDLE) && instr_boundary && !bus.hdl_busy && any_eligible;
  assign ack_fire = (state == REQ) && bus.req_ack;

  // Clear only the pending bit of the kind actually presented; IRQ has none.
  assign clr_rst = ack_fire && (bus.req_kind == KIND_RST);
  assign clr_nmi = ack_fire && (bus.req_kind == KIND_NMI);
  assign clr_brk = ack_fire && (bus.req_kind == KIND_BRK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      nmi_q          <= 1'b0;
      rst_pend       <= 1'b0;
      nmi_pend       <= 1'b0;
      brk_pend       <= 1'b0;
      bus.req_valid  <= 1'b0;
      bus.req_vector <= 16'h0000;
      bus.req_kind   <= 2'b00;
      nmi_count      <= 8'd0;
    end else begin
      nmi_q <= nmi_src;

      // A new event on the same edge as its own ack keeps the bit set.
      rst_pend <= (rst_pend & ~clr_rst) | soft_reset;
      nmi_pend <= (nmi_pend & ~clr_nmi) | nmi_rise;
      brk_pend <= (brk_pend & ~clr_brk) | brk;

      case (state)
        IDLE: begin
          if (take) begin
            state          <= REQ;
            bus.req_valid  <= 1'b1;
            bus.req_vector <= sel_vector;
            bus.req_kind   <= sel_kind;
          end
        end
        REQ: begin
          // Presented vector/kind are frozen here; newer events only
          // accumulate in the pending bits.
          if (bus.req_ack) begin
            state         <= SERVICE;
            bus.req_valid <= 1'b0;
            if (bus.req_kind == KIND_NMI) begin
              nmi_count <= nmi_count + 8'd1;
            end
          end
        end
        SERVICE: begin
          if (!bus.hdl_busy) begin
            state <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_request_ctrl.sv
module tb_interrupt_request_ctrl;

`ifdef IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       nmi_src;
  logic       irq_n;
  logic       soft_reset;
  logic       brk;
  logic       i_flag;
  logic       instr_boundary;
  logic [7:0] nmi_count;

  interrupt_request_ctrl_if bus ();

  interrupt_request_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .nmi_src        (nmi_src),
    .irq_n          (irq_n),
    .soft_reset     (soft_reset),
    .brk            (brk),
    .i_flag         (i_flag),
    .instr_boundary (instr_boundary),
    .bus            (bus.master),
    .nmi_count      (nmi_count)
  );

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (transaction level) ----------------
  // Pending events per kind: 0 reset, 1 NMI, 2 BRK.
  bit          m_pend [3];
  int          m_phase;        // 0 waiting, 1 presenting, 2 handler running
  bit          m_valid;
  bit [1:0]    m_kind;
  bit [15:0]   m_vec;
  int          m_nmis;
  bit          m_nmi_prev;

  function automatic bit [15:0] vec_of(input int k);
    case (k)
      0:       return 16'hFFFC;
      1:       return 16'hFFFA;
      default: return 16'hFFFE;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_pend[k] = 1'b0;
    m_phase    = 0;
    m_valid    = 1'b0;
    m_kind     = 2'b00;
    m_vec      = 16'h0000;
    m_nmis     = 0;
    m_nmi_prev = 1'b0;
  endtask

  // One clock edge of the model, from the inputs seen just before the edge.
  task automatic model_step(input bit s_nmi, input bit s_irqn, input bit s_soft,
                            input bit s_brk, input bit s_if, input bit s_bnd,
                            input bit s_busy, input bit s_ack);
    bit events [3];
    bit served [3];
    bit irq_ok;
    int pick;
    events[0] = s_soft;
    events[1] = s_nmi && !m_nmi_prev;
    events[2] = s_brk;
    for (int k = 0; k < 3; k++) served[k] = 1'b0;
    irq_ok = IRQ_ON && !s_irqn && !s_if;
    if (m_phase == 0) begin
      if (s_bnd && !s_busy) begin
        pick = -1;
        for (int k = 2; k >= 0; k--) if (m_pend[k]) pick = k;
        if (pick < 0 && irq_ok) pick = 3;
        if (pick >= 0) begin
          m_phase = 1;
          m_valid = 1'b1;
          m_kind  = 2'(pick);
          m_vec   = vec_of(pick);
        end
      end
    end else if (m_phase == 1) begin
      if (s_ack) begin
        m_phase = 2;
        m_valid = 1'b0;
        if (m_kind != 2'd3) served[m_kind] = 1'b1;
        if (m_kind == 2'd1) m_nmis = (m_nmis + 1) % 256;
      end
    end else begin
      if (!s_busy) m_phase = 0;
    end
    for (int k = 0; k < 3; k++) m_pend[k] = (m_pend[k] && !served[k]) || events[k];
    m_nmi_prev = s_nmi;
  endtask

  // Cycle with model update; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    bit s_nmi, s_irqn, s_soft, s_brk, s_if, s_bnd, s_busy, s_ack;
    s_nmi  = nmi_src;  s_irqn = irq_n;  s_soft = soft_reset; s_brk = brk;
    s_if   = i_flag;   s_bnd  = instr_boundary;
    s_busy = bus.hdl_busy; s_ack = bus.req_ack;
    @(posedge clk);
    model_step(s_nmi, s_irqn, s_soft, s_brk, s_if, s_bnd, s_busy, s_ack);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst            = 1'b0;
    nmi_src        = 1'b0;
    irq_n          = 1'b1;
    soft_reset     = 1'b0;
    brk            = 1'b0;
    i_flag         = 1'b1;
    instr_boundary = 1'b0;
    bus.hdl_busy   = 1'b0;
    bus.req_ack    = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic pulse_boundary();
    instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    apply_reset();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.req_valid); end
    checks++;
    if (bus.req_vector !== 16'h0000) begin failures++; $display("FAIL reset_vector: got %h expected 0000", bus.req_vector); end
    checks++;
    if (bus.req_kind !== 2'b00) begin failures++; $display("FAIL reset_kind: got %b expected 00", bus.req_kind); end
    checks++;
    if (nmi_count !== 8'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", nmi_count); end
    rst = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_nmi_held();
    apply_reset();
    nmi_src = 1'b1;
    repeat (10) tick();
    pulse_boundary();
    checks++;
    if (bus.req_valid !== 1'b1 || bus.req_vector !== 16'hFFFA || bus.req_kind !== 2'b01) begin
      failures++;
      $display("FAIL nmi_req: got valid=%b vec=%h kind=%b expected 1 FFFA 01", bus.req_valid, bus.req_vector, bus.req_kind);
    end
    bus.req_ack = 1'b1; bus.hdl_busy = 1'b1;
    tick();
    bus.req_ack = 1'b0;
    checks++;
    if (bus.req_valid !== 1'b0 || nmi_count !== 8'd1) begin
      failures++;
      $display("FAIL nmi_ack: got valid=%b count=%0d expected 0 1", bus.req_valid, nmi_count);
    end
    bus.hdl_busy = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      pulse_boundary();
      checks++;
      if (bus.req_valid !== 1'b0) begin failures++; $display("FAIL nmi_held_retrigger: got valid=%b expected 0", bus.req_valid); end
      tick();
    end
    nmi_src = 1'b0;
    tick();
    $display("test_nmi_held done count=%0d", nmi_count);
  endtask

  task automatic test_reset_and_nmi();
    apply_reset();
    soft_reset = 1'b1; nmi_src = 1'b1;
    tick();
    soft_reset = 1'b0;
    pulse_boundary();
    checks++;
    if (bus.req_valid !== 1'b1 || bus.req_vector !== 16'hFFFC || bus.req_kind !== 2'b00) begin
      failures++;
      $display("FAIL prio_first: got valid=%b vec=%h kind=%b expected 1 FFFC 00", bus.req_valid, bus.req_vector, bus.req_kind);
    end
    bus.req_ack = 1'b1;
    tick();
    bus.req_ack = 1'b0;
    tick();
    pulse_boundary();
    checks++;
    if (bus.req_valid !== 1'b1 || bus.req_vector !== 16'hFFFA || bus.req_kind !== 2'b01) begin
      failures++;
      $display("FAIL prio_second: got valid=%b vec=%h kind=%b expected 1 FFFA 01", bus.req_valid, bus.req_vector, bus.req_kind);
    end
    bus.req_ack = 1'b1;
    tick();
    bus.req_ack = 1'b0;
    nmi_src = 1'b0;
    tick();
    $display("test_reset_and_nmi done");
  endtask

  task automatic test_irq_mask();
    bit        exp_valid;
    bit [15:0] exp_vec;
    bit [1:0]  exp_kind;
    apply_reset();
    irq_n = 1'b0; i_flag = 1'b1;
    pulse_boundary();
    checks++;
    if (bus.req_valid !== 1'b0) begin failures++; $display("FAIL irq_masked: got valid=%b expected 0", bus.req_valid); end
    tick();
    i_flag = 1'b0;
    pulse_boundary();
    exp_valid = IRQ_ON;
    exp_vec   = IRQ_ON ? 16'hFFFE : 16'h0000;
    exp_kind  = IRQ_ON ? 2'b11 : 2'b00;
    checks++;
    if (bus.req_valid !== exp_valid || bus.req_vector !== exp_vec || bus.req_kind !== exp_kind) begin
      failures++;
      $display("FAIL irq_unmasked: got valid=%b vec=%h kind=%b expected %b %h %b",
               bus.req_valid, bus.req_vector, bus.req_kind, exp_valid, exp_vec, exp_kind);
    end
    irq_n = 1'b1; i_flag = 1'b1;
    bus.req_ack = 1'b1;
    tick();
    bus.req_ack = 1'b0;
    tick();
    $display("test_irq_mask done irq_on=%0d", IRQ_ON);
  endtask

  task automatic test_brk_then_nmi();
    apply_reset();
    // ack while idle with nothing presented must be ignored
    bus.req_ack = 1'b1;
    tick();
    bus.req_ack = 1'b0;
    brk = 1'b1;
    tick();
    brk = 1'b0;
    pulse_boundary();
    checks++;
    if (bus.req_valid !== 1'b1 || bus.req_vector !== 16'hFFFE || bus.req_kind !== 2'b10) begin
      failures++;
      $display("FAIL brk_req: got valid=%b vec=%h kind=%b expected 1 FFFE 10", bus.req_valid, bus.req_vector, bus.req_kind);
    end
    nmi_src = 1'b1;
    repeat (2) begin
      tick();
      checks++;
      if (bus.req_valid !== 1'b1 || bus.req_vector !== 16'hFFFE || bus.req_kind !== 2'b10) begin
        failures++;
        $display("FAIL brk_stable: got valid=%b vec=%h kind=%b expected 1 FFFE 10", bus.req_valid, bus.req_vector, bus.req_kind);
      end
    end
    bus.req_ack = 1'b1; bus.hdl_busy = 1'b1;
    tick();
    bus.req_ack = 1'b0;
    pulse_boundary();
    checks++;
    if (bus.req_valid !== 1'b0 || nmi_count !== 8'd0) begin
      failures++;
      $display("FAIL brk_service_hold: got valid=%b count=%0d expected 0 0", bus.req_valid, nmi_count);
    end
    bus.hdl_busy = 1'b0;
    tick();
    pulse_boundary();
    checks++;
    if (bus.req_valid !== 1'b1 || bus.req_vector !== 16'hFFFA || bus.req_kind !== 2'b01) begin
      failures++;
      $display("FAIL brk_then_nmi: got valid=%b vec=%h kind=%b expected 1 FFFA 01", bus.req_valid, bus.req_vector, bus.req_kind);
    end
    bus.req_ack = 1'b1;
    tick();
    bus.req_ack = 1'b0;
    nmi_src = 1'b0;
    tick();
    $display("test_brk_then_nmi done");
  endtask

  task automatic test_reset_in_service();
    apply_reset();
    brk = 1'b1;
    tick();
    brk = 1'b0;
    pulse_boundary();
    bus.req_ack = 1'b1; bus.hdl_busy = 1'b1;
    tick();
    bus.req_ack = 1'b0;
    nmi_src = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_valid !== 1'b0 || bus.req_vector !== 16'h0000 || bus.req_kind !== 2'b00 || nmi_count !== 8'd0) begin
      failures++;
      $display("FAIL async_reset: got valid=%b vec=%h kind=%b count=%0d expected 0 0000 00 0",
               bus.req_valid, bus.req_vector, bus.req_kind, nmi_count);
    end
    nmi_src = 1'b0; bus.hdl_busy = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    pulse_boundary();
    checks++;
    if (bus.req_valid !== 1'b0) begin failures++; $display("FAIL reset_discard: got valid=%b expected 0", bus.req_valid); end
    tick();
    $display("test_reset_in_service done");
  endtask

  task automatic test_nmi_wrap();
    apply_reset();
    for (int i = 1; i <= 256; i++) begin
      nmi_src = 1'b1;
      tick();
      nmi_src = 1'b0;
      pulse_boundary();
      bus.req_ack = 1'b1;
      tick();
      bus.req_ack = 1'b0;
      tick();
      if (i == 255) begin
        checks++;
        if (nmi_count !== 8'd255) begin failures++; $display("FAIL nmi_count_255: got %0d expected 255", nmi_count); end
      end
    end
    checks++;
    if (nmi_count !== 8'd0) begin failures++; $display("FAIL nmi_count_wrap: got %0d expected 0", nmi_count); end
    $display("test_nmi_wrap done count=%0d", nmi_count);
  endtask

  // ---------------- randomized run against the model ----------------
  task automatic test_random();
    int n_req;
    n_req = 0;
    apply_reset();
    for (int c = 0; c < 4000; c++) begin
      soft_reset     = ($urandom_range(0, 39) == 0);
      brk            = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) nmi_src = ~nmi_src;
      if ($urandom_range(0, 7) == 0) irq_n = ~irq_n;
      if ($urandom_range(0, 5) == 0) i_flag = ~i_flag;
      instr_boundary = ($urandom_range(0, 2) == 0);
      bus.hdl_busy   = ($urandom_range(0, 2) == 0);
      bus.req_ack    = ($urandom_range(0, 4) < 2);
      cyc();
      if (m_valid) n_req++;
      checks++;
      if (bus.req_valid !== m_valid || bus.req_vector !== m_vec || bus.req_kind !== m_kind ||
          nmi_count !== 8'(m_nmis)) begin
        failures++;
        $display("FAIL random_c%0d: got valid=%b vec=%h kind=%b count=%0d expected %b %h %b %0d",
                 c, bus.req_valid, bus.req_vector, bus.req_kind, nmi_count,
                 m_valid, m_vec, m_kind, m_nmis);
      end
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        #2;
        model_reset();
        checks++;
        if (bus.req_valid !== 1'b0 || nmi_count !== 8'd0) begin
          failures++;
          $display("FAIL random_async_reset: got valid=%b count=%0d expected 0 0", bus.req_valid, nmi_count);
        end
        rst = 1'b1;
      end
    end
    $display("test_random done presenting_cycles=%0d", n_req);
  endtask

  initial begin
    test_reset();
    test_nmi_held();
    test_reset_and_nmi();
    test_irq_mask();
    test_brk_then_nmi();
    test_reset_in_service();
    test_nmi_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
